// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
// -----------------------------------------------------------------------------
// Initiator-side built-in self-test controller for a single-port RAM. A start
// pulse in IDLE launches two passes over the whole address space. Each pass
// writes a deterministic pattern to every word and then reads every word back.
// Each read waits for the RAM's out_en strobe, bounded by a timeout, and the
// returned data is compared with the pattern. Pass 0 writes P(a) = SEED ^ a.
// Pass 1 writes ~P(a), so every cell is exercised at both polarities. Results
// are kept until the next accepted start.
//
// Ports
//   clk             in   system clock, rising edge
//   rstn            in   synchronous active-low reset
//   start           in   one-cycle test request, honoured only in IDLE
//   ram_en          out  RAM enable
//   ram_addr        out  RAM address
//   ram_wr_rd       out  1 = write, 0 = read
//   ram_data_in     out  write data to RAM (held during reads)
//   ram_data_out    in   read data from RAM
//   ram_out_en      in   read data valid (only observed while awaiting a read)
//   busy            out  high in every state except IDLE
//   done            out  one-cycle completion pulse
//   pass            out  no errors in the last completed test
//   err_count       out  mismatches plus timeouts (max 2*DEPTH)
//   first_fail_addr out  address of the first error, 0 if none
//   timeout_err     out  sticky: at least one read timed out
// -----------------------------------------------------------------------------
module ram_bist_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5,
  parameter int                    TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_rd,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_out_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic                  timeout_err
);

  localparam int CNT_W = ADDR_WIDTH + 2;
  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [TMR_W-1:0]      TMR_LIMIT = TMR_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    phase_q;
  logic [TMR_W-1:0]        timer_q;
  logic                    ram_en_q;
  logic                    ram_wr_rd_q;
  logic [DATA_WIDTH-1:0]   ram_data_in_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [CNT_W-1:0]        err_count_q;
  logic [ADDR_WIDTH-1:0]   first_fail_addr_q;
  logic                    timeout_err_q;

  logic [ADDR_WIDTH-1:0]   addr_inc_d;
  logic [DATA_WIDTH-1:0]   exp_data_d;
  logic                    read_lost_d;
  logic                    read_end_d;
  logic                    read_err_d;
  logic [CNT_W-1:0]        err_count_d;

  // Pattern for address a in the given phase; the address is zero-extended
  // or truncated to the data width before mixing with the seed.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic ph);
    logic [DATA_WIDTH-1:0] base;
    base = SEED ^ DATA_WIDTH'(a);
    return ph ? ~base : base;
  endfunction

  // Read-completion decode for RD_WAIT. A valid strobe takes priority over a
  // timer expiring in the same cycle.
  always_comb begin
    addr_inc_d  = addr_q + ADDR_WIDTH'(1);
    exp_data_d  = pattern(addr_q, phase_q);
    read_lost_d = !ram_out_en && (timer_q == TMR_LIMIT);
    read_end_d  = ram_out_en || read_lost_d;
    read_err_d  = ram_out_en ? (ram_data_out != exp_data_d) : read_lost_d;
    err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, read_err_d};
  end

  // Single state register; every output is loaded together with the state it
  // belongs to, so outputs are valid in the same cycle as the state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q           <= S_IDLE;
      addr_q            <= '0;
      phase_q           <= 1'b0;
      timer_q           <= '0;
      ram_en_q          <= 1'b0;
      ram_wr_rd_q       <= 1'b0;
      ram_data_in_q     <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      first_fail_addr_q <= '0;
      timeout_err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_count_q       <= '0;
            first_fail_addr_q <= '0;
            timeout_err_q     <= 1'b0;
            pass_q            <= 1'b0;
            addr_q            <= '0;
            phase_q           <= 1'b0;
            busy_q            <= 1'b1;
            ram_en_q          <= 1'b1;
            ram_wr_rd_q       <= 1'b1;
            ram_data_in_q     <= pattern('0, 1'b0);
            state_q           <= S_WR;
          end
        end

        S_WR: begin
          if (addr_q == LAST_ADDR) begin
            addr_q      <= '0;
            ram_wr_rd_q <= 1'b0;
            state_q     <= S_RD;
          end else begin
            addr_q        <= addr_inc_d;
            ram_data_in_q <= pattern(addr_inc_d, phase_q);
          end
        end

        S_RD: begin
          timer_q <= '0;
          state_q <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (read_end_d) begin
            if (read_err_d) begin
              err_count_q <= err_count_d;
              if (err_count_q == '0) begin
                first_fail_addr_q <= addr_q;
              end
            end
            if (read_lost_d) begin
              timeout_err_q <= 1'b1;
            end
            if (addr_q != LAST_ADDR) begin
              addr_q  <= addr_inc_d;
              state_q <= S_RD;
            end else if (!phase_q) begin
              // Second pass rewrites every word with the inverted pattern.
              phase_q       <= 1'b1;
              addr_q        <= '0;
              ram_wr_rd_q   <= 1'b1;
              ram_data_in_q <= pattern('0, 1'b1);
              state_q       <= S_WR;
            end else begin
              // err_count_d includes this final read's result.
              ram_en_q <= 1'b0;
              done_q   <= 1'b1;
              pass_q   <= (err_count_d == '0);
              state_q  <= S_DONE;
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_en          = ram_en_q;
  assign ram_addr        = addr_q;
  assign ram_wr_rd       = ram_wr_rd_q;
  assign ram_data_in     = ram_data_in_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_fail_addr = first_fail_addr_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Testbench for ram_bist_ctrl: a behavioural single-port RAM with fault
// injection (stuck-at-0 bits per address, a lost-read address, spurious
// out_en), and a result scoreboard filled when a test is launched and drained
// when the controller pulses done.
module tb_ram_bist_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = AW + 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic          ram_wr_rd;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic          ram_out_en;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_fail_addr;
  logic          timeout_err;

  always #5 clk = ~clk;

  ram_bist_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .SEED      (8'hA5),
    .TIMEOUT   (15)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .ram_en         (ram_en),
    .ram_addr       (ram_addr),
    .ram_wr_rd      (ram_wr_rd),
    .ram_data_in    (ram_data_in),
    .ram_data_out   (ram_data_out),
    .ram_out_en     (ram_out_en),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_addr(first_fail_addr),
    .timeout_err    (timeout_err)
  );

  // ---------------------------------------------------------------- checking
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- RAM model
  logic [DW-1:0] mem      [DEPTH];
  logic [DW-1:0] and_mask [DEPTH];
  bit            drop_en   = 1'b0;
  int            drop_addr = 0;
  bit            spur_oe   = 1'b0;
  logic          oe_q      = 1'b0;
  logic [DW-1:0] rd_q      = '0;

  always @(posedge clk) begin
    if (ram_en && ram_wr_rd) mem[ram_addr] <= ram_data_in;
    if (ram_en && !ram_wr_rd) rd_q <= mem[ram_addr] & ~and_mask[ram_addr];
    oe_q <= ram_en && !ram_wr_rd && !(drop_en && (int'(ram_addr) == drop_addr));
  end

  assign ram_data_out = rd_q;
  assign ram_out_en   = oe_q | spur_oe;

  // ---------------------------------------------------------------- reference
  typedef struct {
    logic          pass;
    logic [CW-1:0] err;
    logic [AW-1:0] ffa;
    logic          tmo;
    int            lat;
  } exp_t;

  exp_t sb[$];

  function automatic logic [DW-1:0] pat(input int a, input bit ph);
    logic [DW-1:0] v;
    v = 8'hA5 ^ DW'(a);
    return ph ? ~v : v;
  endfunction

  function automatic exp_t model();
    exp_t          m;
    logic [DW-1:0] p;
    bit            bad;
    m.pass = 1'b0;
    m.err  = '0;
    m.ffa  = '0;
    m.tmo  = 1'b0;
    m.lat  = -1;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < DEPTH; a++) begin
        p = pat(a, ph[0]);
        if (drop_en && a == drop_addr) begin
          bad   = 1'b1;
          m.tmo = 1'b1;
        end else begin
          bad = ((p & ~and_mask[a]) != p);
        end
        if (bad) begin
          if (m.err == '0) m.ffa = AW'(a);
          m.err = m.err + CW'(1);
        end
      end
    end
    m.pass = (m.err == '0);
    return m;
  endfunction

  // ---------------------------------------------------------------- monitor
  int cyc       = 0;
  int start_cyc = 0;
  int wr_cnt    = 0;
  bit prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rstn) begin
      wr_cnt    <= 0;
      prev_done <= 1'b0;
    end else begin
      if (!busy) begin
        wr_cnt <= 0;
      end else if (ram_en && ram_wr_rd) begin
        check("wr_addr", ram_addr, wr_cnt % DEPTH);
        check("wr_data", ram_data_in, pat(wr_cnt % DEPTH, wr_cnt >= DEPTH));
        wr_cnt <= wr_cnt + 1;
      end
      if (done) begin
        $display("[TB] done at cycle %0d: pass=%0b err_count=%0d first_fail_addr=%0d timeout_err=%0b",
                 cyc - start_cyc, pass, err_count, first_fail_addr, timeout_err);
        check("done_width", prev_done, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("pass", pass, sb[0].pass);
          check("err_count", err_count, sb[0].err);
          check("first_fail_addr", first_fail_addr, sb[0].ffa);
          check("timeout_err", timeout_err, sb[0].tmo);
          check("wr_total", wr_cnt, 2 * DEPTH);
          if (sb[0].lat >= 0) check("latency", cyc - start_cyc, sb[0].lat);
          void'(sb.pop_front());
        end
      end
      prev_done <= done;
    end
  end

  // ---------------------------------------------------------------- stimulus
  // mode: 0 plain, 1 timeline probes, 2 ignored start pulses, 3 spurious out_en
  task automatic run(input int lat, input int mode);
    exp_t e;
    int   n;
    bit   got;
    e     = model();
    e.lat = lat;
    sb.push_back(e);
    start     = 1'b1;
    start_cyc = cyc;
    got = 1'b0;
    n   = 0;
    while (!got && n < 600) begin
      @(negedge clk);
      n++;
      start   = 1'b0;
      spur_oe = 1'b0;
      if (mode == 2 && n == 30) start = 1'b1;
      if (mode == 3 && (n == 5 || n == 6)) spur_oe = 1'b1;
      if (mode == 1) begin
        if (n == 16) check("wr_last", {ram_en, ram_wr_rd, ram_addr}, 6'b11_1111);
        if (n == 17) check("rd_first", {ram_en, ram_wr_rd, ram_addr}, 6'b10_0000);
        if (n == 49) check("ph1_wr_data", ram_data_in, 8'h5A);
      end
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", 0, 1);
    if (mode == 2) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", busy, 0);
    repeat (4) @(negedge clk);
    check("idle_busy", busy, 0);
    check("pass_held", pass, e.pass);
    check("err_held", err_count, e.err);
  endtask

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) and_mask[i] = '0;
    drop_en   = 1'b0;
    drop_addr = 0;
    spur_oe   = 1'b0;
  endtask

  initial begin
    int n;
    rstn  = 1'b0;
    start = 1'b0;
    clear_faults();
    repeat (3) @(negedge clk);
    check("reset_state",
          {ram_en, ram_wr_rd, busy, done, pass, timeout_err, err_count, first_fail_addr, ram_addr}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: ideal RAM
    run(97, 1);

    // 2: bit 0 stuck low at address 3
    and_mask[3] = 8'h01;
    run(97, 0);
    clear_faults();

    // 3: address 5 never returns out_en
    drop_en   = 1'b1;
    drop_addr = 5;
    run(-1, 0);
    clear_faults();

    // 4: reset during phase-0 reads after an error has been recorded
    drop_en   = 1'b1;
    drop_addr = 5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (err_count == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("s4_err_seen", err_count != '0, 1);
    check("s4_pre_ffa", first_fail_addr, 5);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("s4_reset_state",
          {ram_en, ram_wr_rd, busy, done, pass, timeout_err, err_count, first_fail_addr}, 0);
    rstn = 1'b1;
    clear_faults();
    @(negedge clk);
    run(97, 1);

    // 5: start pulses while busy and in DONE are ignored
    run(97, 2);

    // 6: spurious out_en in IDLE and WR, errors at addresses 2 and 9
    and_mask[2] = 8'h01;
    and_mask[9] = 8'h01;
    spur_oe = 1'b1;
    repeat (2) @(negedge clk);
    spur_oe = 1'b0;
    run(97, 3);
    clear_faults();

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
